// File: rtl/voice_alloc_pkg.sv
// ============================================================
// voice_alloc_pkg: shared voice state encoding and default widths.
// Rev 1.0
// ============================================================
`default_nettype none

package voice_alloc_pkg;

  localparam int DEFAULT_NUM_VOICES = 3;
  localparam int DEFAULT_NOTE_W     = 6;
  localparam int DEFAULT_DUR_W      = 6;
  localparam int REST_NOTE          = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } voice_state_t;

endpackage

`default_nettype wire

// File: rtl/voice_slot.sv
// ============================================================
// voice_slot: one voice's IDLE/LOAD/PLAY sequencer and beat counter.
// Rev 1.0
// ============================================================
`default_nettype none

module voice_slot
  import voice_alloc_pkg::*;
#(
  parameter int DUR_W = DEFAULT_DUR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DUR_W-1:0] load_duration,
  input  logic             play_enable,
  input  logic             beat,
  output voice_state_t     state,
  output logic [DUR_W-1:0] remaining,
  output logic             busy
);

  voice_state_t     r_state;
  logic [DUR_W-1:0] r_remaining;

  // A load always wins, so a stolen voice restarts cleanly through LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_remaining <= '0;
    end else if (load) begin
      r_state     <= LOAD;
      r_remaining <= load_duration;
    end else begin
      case (r_state)
        LOAD: r_state <= PLAY;
        PLAY: begin
          if (beat && play_enable && (r_remaining != '0)) begin
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == DUR_W'(1)) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign state     = r_state;
  assign remaining = r_remaining;
  assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: rtl/voice_allocator.sv
// ============================================================
// voice_allocator: assigns note requests to the lowest free voice.
// Optional macro VOICE_STEAL_EN: steal the shortest-remaining voice when full.
// Rev 1.0
// ============================================================
`default_nettype none

module voice_allocator
  import voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
  parameter int NOTE_W     = DEFAULT_NOTE_W,
  parameter int DUR_W      = DEFAULT_DUR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_note,
  input  logic [NOTE_W-1:0]     note_to_load,
  input  logic [DUR_W-1:0]      duration_to_load,
  input  logic                  play_enable,
  input  logic                  beat,
  output logic [NUM_VOICES-1:0] voice_load,
  output logic [NOTE_W-1:0]     voice_note,
  output logic [DUR_W-1:0]      voice_duration,
  output logic [NUM_VOICES-1:0] voice_busy,
  output logic                  player_available,
  output logic                  note_dropped
);

  voice_state_t          w_state     [NUM_VOICES];
  logic [DUR_W-1:0]      w_remaining [NUM_VOICES];
  logic [NUM_VOICES-1:0] w_busy;
  logic [NUM_VOICES-1:0] w_sel;
  logic                  w_req_valid;
  logic                  w_found;
  logic                  w_drop;

  logic [NUM_VOICES-1:0] r_voice_load;
  logic [NOTE_W-1:0]     r_voice_note;
  logic [DUR_W-1:0]      r_voice_duration;
  logic                  r_note_dropped;

`ifdef VOICE_STEAL_EN
  logic [DUR_W-1:0]      w_best;
  logic                  w_have;
  logic [NUM_VOICES-1:0] w_victim;
`endif

  assign w_req_valid = new_note && (note_to_load != NOTE_W'(REST_NOTE))
                       && (duration_to_load != '0);

  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    w_drop  = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (w_req_valid && !w_found && (w_state[i] == IDLE)) begin
        w_sel[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
`ifdef VOICE_STEAL_EN
    w_best   = '1;
    w_have   = 1'b0;
    w_victim = '0;
    // Strict compare keeps the lowest index on equal remaining counts.
    for (int i = 0; i < NUM_VOICES; i++) begin
      if ((w_state[i] == PLAY) && (!w_have || (w_remaining[i] < w_best))) begin
        w_best      = w_remaining[i];
        w_have      = 1'b1;
        w_victim    = '0;
        w_victim[i] = 1'b1;
      end
    end
    if (w_req_valid && !w_found) w_sel = w_victim;
`else
    w_drop = w_req_valid && !w_found;
`endif
  end

  generate
    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
      voice_slot #(
        .DUR_W(DUR_W)
      ) u_slot (
        .clk          (clk),
        .reset        (reset),
        .load         (w_sel[g]),
        .load_duration(duration_to_load),
        .play_enable  (play_enable),
        .beat         (beat),
        .state        (w_state[g]),
        .remaining    (w_remaining[g]),
        .busy         (w_busy[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_voice_load     <= '0;
      r_voice_note     <= '0;
      r_voice_duration <= '0;
      r_note_dropped   <= 1'b0;
    end else begin
      r_voice_load   <= w_sel;
      r_note_dropped <= w_drop;
      if (|w_sel) begin
        r_voice_note     <= note_to_load;
        r_voice_duration <= duration_to_load;
      end
    end
  end

  assign voice_load       = r_voice_load;
  assign voice_note       = r_voice_note;
  assign voice_duration   = r_voice_duration;
  assign note_dropped     = r_note_dropped;
  assign voice_busy       = w_busy;
  assign player_available = ~&w_busy;

endmodule

`default_nettype wire

// File: tb/tb_voice_allocator.sv
// ============================================================
// tb_voice_allocator: directed plus random stimulus against a reference model.
// Rev 1.0
// ============================================================
`default_nettype none

module tb_voice_allocator;

  localparam int NV = 3;
  localparam int NW = 6;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          new_note = 1'b0;
  logic [NW-1:0] note_to_load = '0;
  logic [DW-1:0] duration_to_load = '0;
  logic          play_enable = 1'b0;
  logic          beat = 1'b0;
  logic [NV-1:0] voice_load;
  logic [NW-1:0] voice_note;
  logic [DW-1:0] voice_duration;
  logic [NV-1:0] voice_busy;
  logic          player_available;
  logic          note_dropped;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  voice_allocator #(
    .NUM_VOICES(NV),
    .NOTE_W    (NW),
    .DUR_W     (DW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .new_note        (new_note),
    .note_to_load    (note_to_load),
    .duration_to_load(duration_to_load),
    .play_enable     (play_enable),
    .beat            (beat),
    .voice_load      (voice_load),
    .voice_note      (voice_note),
    .voice_duration  (voice_duration),
    .voice_busy      (voice_busy),
    .player_available(player_available),
    .note_dropped    (note_dropped)
  );

  // Model: a voice is either free, in its load cycle, or playing with m_rem beats left.
  int            m_rem     [NV];
  bit            m_loading [NV];
  bit            m_play    [NV];
  logic [NV-1:0] m_vload;
  logic [NW-1:0] m_vnote;
  logic [DW-1:0] m_vdur;
  bit            m_drop;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NV-1:0] model_busy();
    logic [NV-1:0] b;
    for (int i = 0; i < NV; i++) b[i] = m_loading[i] || m_play[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_rem[i] = 0;
      m_loading[i] = 1'b0;
      m_play[i] = 1'b0;
    end
    m_vload = '0;
    m_vnote = '0;
    m_vdur  = '0;
    m_drop  = 1'b0;
  endtask

  task automatic check_all();
    check("voice_load", 64'(voice_load), 64'(m_vload));
    check("voice_note", 64'(voice_note), 64'(m_vnote));
    check("voice_duration", 64'(voice_duration), 64'(m_vdur));
    check("voice_busy", 64'(voice_busy), 64'(model_busy()));
    check("player_available", 64'(player_available), 64'(~&model_busy()));
    check("note_dropped", 64'(note_dropped), 64'(m_drop));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_load"}, 64'(voice_load), 64'd0);
    check({tag, "_note"}, 64'(voice_note), 64'd0);
    check({tag, "_dur"}, 64'(voice_duration), 64'd0);
    check({tag, "_busy"}, 64'(voice_busy), 64'd0);
    check({tag, "_avail"}, 64'(player_available), 64'd1);
    check({tag, "_drop"}, 64'(note_dropped), 64'd0);
  endtask

  task automatic model_step(input bit nn, input int note, input int dur, input bit pe, input bit bt);
    int target;
    bit valid;
`ifdef VOICE_STEAL_EN
    int best;
`endif
    target = -1;
    valid  = nn && (note != 0) && (dur != 0);
    m_drop = 1'b0;
    if (valid) begin
      for (int i = 0; i < NV; i++)
        if (target < 0 && !m_loading[i] && !m_play[i]) target = i;
      if (target < 0) begin
`ifdef VOICE_STEAL_EN
        best = 1 << 30;
        for (int i = 0; i < NV; i++)
          if (m_play[i] && m_rem[i] < best) begin
            best   = m_rem[i];
            target = i;
          end
`else
        m_drop = 1'b1;
`endif
      end
    end
    for (int i = 0; i < NV; i++) begin
      if (i == target) begin
        m_loading[i] = 1'b1;
        m_play[i]    = 1'b0;
        m_rem[i]     = dur;
      end else if (m_loading[i]) begin
        m_loading[i] = 1'b0;
        m_play[i]    = 1'b1;
      end else if (m_play[i] && pe && bt) begin
        m_rem[i] = m_rem[i] - 1;
        if (m_rem[i] == 0) m_play[i] = 1'b0;
      end
    end
    m_vload = '0;
    if (target >= 0) begin
      m_vload[target] = 1'b1;
      m_vnote = NW'(note);
      m_vdur  = DW'(dur);
    end
  endtask

  task automatic cycle(input bit nn, input int note, input int dur, input bit pe, input bit bt);
    @(negedge clk);
    check_all();
    new_note         = nn;
    note_to_load     = NW'(note);
    duration_to_load = DW'(dur);
    play_enable      = pe;
    beat             = bt;
    model_step(nn, note, dur, pe, bt);
  endtask

  // Reset lands mid-cycle; a request held during reset must be ignored.
  task automatic do_reset(input string tag);
    @(negedge clk);
    check_all();
    #2;
    reset            = 1'b0;
    new_note         = 1'b1;
    note_to_load     = NW'(33);
    duration_to_load = DW'(4);
    beat             = 1'b1;
    #1;
    check_reset_values(tag);
    model_reset();
    @(negedge clk);
    check_reset_values({tag, "_held"});
    reset    = 1'b1;
    new_note = 1'b0;
    beat     = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    check_reset_values("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // First note, then count it out with sparse beats.
    cycle(1, 57, 5, 1, 0);
    cycle(0, 0, 0, 1, 0);
    check("first_load", 64'(voice_load), 64'b001);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, i % 2);

    // Fill all voices back to back, then one more request.
    cycle(1, 1, 8, 1, 0);
    cycle(1, 51, 3, 1, 0);
    cycle(1, 10, 5, 1, 0);
    cycle(1, 20, 2, 1, 0);
    cycle(0, 0, 0, 1, 0);
    check("full_available", 64'(player_available), 64'd0);
    cycle(0, 0, 0, 1, 1);

    // Pause for ten beats, then resume.
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, i % 2);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 1);

    // Rest and zero-length requests.
    cycle(1, 0, 4, 1, 0);
    cycle(1, 9, 0, 1, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, 1);

    // Load all three voices, then reset while they play.
    cycle(1, 3, 30, 1, 0);
    cycle(1, 4, 30, 1, 0);
    cycle(1, 5, 30, 1, 0);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    do_reset("midplay");

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset("rand");
      end else begin
        cycle(($urandom_range(0, 2) == 0),
              ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 63)),
              ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 6)),
              ($urandom_range(0, 7) != 0),
              ($urandom_range(0, 1) == 1));
      end
    end
    @(negedge clk);
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 3, number of note players scheduled.
REQ-002 SHALL have parameter NOTE_W, default 6, note code width.
REQ-003 SHALL have parameter DUR_W, default 6, duration width in beats.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port new_note  input  1  one-cycle request to schedule a note.
REQ-007 SHALL have port note_to_load  input  NOTE_W  note code, valid with new_note; 0 = rest.
REQ-008 SHALL have port duration_to_load  input  DUR_W  note length in beats, valid with new_note.
REQ-009 SHALL have port play_enable  input  1  high = durations advance; low = pause.
REQ-010 SHALL have port beat  input  1  one-cycle beat tick.
REQ-011 SHALL have port voice_load  output  NUM_VOICES  one-hot load strobe to note players.
REQ-012 SHALL have port voice_note  output  NOTE_W  note for the strobed player, valid with voice_load.
REQ-013 SHALL have port voice_duration  output  DUR_W  duration for the strobed player, valid with voice_load.
REQ-014 SHALL have port voice_busy  output  NUM_VOICES  per-voice playing flag.
REQ-015 SHALL have port player_available  output  1  high when at least one voice is IDLE.
REQ-016 SHALL have port note_dropped  output  1  one-cycle pulse when a request is discarded.

Function
REQ-017 Each voice SHALL run FSM IDLE -> LOAD (exactly 1 cycle) -> PLAY -> IDLE, holding a DUR_W remaining-beat counter.
REQ-018 A new_note with note_to_load != 0 and duration_to_load != 0 SHALL select the lowest-index IDLE voice (busy state sampled at the start of the cycle); that voice enters LOAD on the next edge.
REQ-019 voice_load, voice_note and voice_duration SHALL be registered; latency from new_note to voice_load = 1 cycle, and voice_load SHALL be high for exactly 1 cycle.
REQ-020 voice_note and voice_duration SHALL hold their last loaded values when voice_load = 0.
REQ-021 A request with note 0 (rest) or duration 0 SHALL be accepted without allocating a voice, without pulsing voice_load or note_dropped.
REQ-022 In PLAY, each cycle with beat = 1 and play_enable = 1 SHALL decrement the counter; at the decrement from 1 to 0 the voice returns to IDLE on the same edge.
REQ-023 play_enable = 0 SHALL freeze all counters and states; new_note SHALL still be allocated while paused.
REQ-024 A voice leaving PLAY in cycle N SHALL NOT be allocatable in cycle N; it becomes eligible in cycle N+1.
REQ-025 A beat coinciding with LOAD SHALL NOT decrement that voice.
REQ-026 voice_busy[i] SHALL be 1 in LOAD and PLAY; player_available = ~&voice_busy, combinational from state.
REQ-027 Duration arithmetic SHALL be unsigned DUR_W bits; counters never wrap below 0.

Reset
REQ-028 Asserting reset (low) SHALL immediately force all voices to IDLE, counters to 0, voice_load, voice_note, voice_duration, note_dropped to 0, voice_busy to 0 and player_available to 1, including mid-LOAD or mid-PLAY.
REQ-029 new_note during reset SHALL be ignored.

Configuration
REQ-030 With macro VOICE_STEAL_EN defined, a non-rest request while all voices are busy SHALL steal the PLAY voice with the smallest remaining count (lowest index on ties), reloading it through LOAD; note_dropped stays 0.
REQ-031 Without VOICE_STEAL_EN, such a request SHALL be discarded and note_dropped pulses for 1 cycle, one cycle after new_note.

Structure
REQ-032 Shared package voice_alloc_pkg SHALL hold the voice state enum (IDLE, LOAD, PLAY), REST_NOTE = 0, and default widths.
REQ-033 Per-voice FSM and counter SHALL be a sub-module voice_slot, instantiated NUM_VOICES times; selection logic stays in voice_allocator.

Verification
REQ-034 Reset then new_note {57,5} -> voice_load = 3'b001 one cycle later, voice_note = 57, voice_duration = 5; voice_busy[0] clears on the 5th enabled beat.
REQ-035 Three back-to-back notes {1,8},{51,3},{10,5} -> loads on voices 0, 1, 2 in consecutive cycles; player_available = 0 afterwards.
REQ-036 Fourth note {20,2} with all busy -> without VOICE_STEAL_EN, note_dropped pulses and voice_load = 0; with VOICE_STEAL_EN, voice 1 (count 3) is reloaded.
REQ-037 play_enable low for 10 beats mid-note -> counters unchanged; resumes counting after play_enable returns high.
REQ-038 Note {0,4} -> no voice_load, no note_dropped, voice_busy unchanged.
REQ-039 Reset asserted mid-PLAY with 3 busy voices -> all outputs at reset values before the next clock edge.
